// File: rtl/lab3_dg_keyscan.sv
// 4x4 keypad scanner: rotating active-low column strobes, press/release debounce,
// and a two-digit key history. Auto-repeat in HELD is built only with KEYSCAN_REPEAT_EN.
module lab3_dg_keyscan #(
  parameter int SCAN_DIV        = 48000,
  parameter int SETTLE_CYCLES   = 2,
  parameter int DEBOUNCE_CYCLES = 960000,
  parameter int REPEAT_CYCLES   = 24000000
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [7:0] keypress,
  output logic       alarm
);

  localparam int DW    = $clog2(SCAN_DIV + 1);
  localparam int BW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int QUIET = 4 * SCAN_DIV;
  localparam int QW    = $clog2(QUIET + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] SETTLE_VAL = DW'(SETTLE_CYCLES);
  localparam logic [BW-1:0] DEB_FULL   = BW'(DEBOUNCE_CYCLES);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);
  localparam logic [QW-1:0] QUIET_FULL = QW'(QUIET);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cols_reg, cols_next;
  logic [DW-1:0]   dwell_reg, dwell_next;
  logic [BW-1:0]   deb_reg, deb_next;
  logic [QW-1:0]   quiet_reg, quiet_next;
  logic [1:0]      row_idx_reg, row_idx_next;
  logic [1:0]      col_idx_reg, col_idx_next;
  logic [3:0]      key_code_reg, key_code_next;
  logic            key_valid_reg, key_valid_next;
  logic [7:0]      keypress_reg, keypress_next;
  logic            alarm_reg, alarm_next;

  logic [3:0]      row_low;
  logic [2:0]      low_cnt;
  logic [1:0]      row_sel;
  logic [1:0]      col_sel;
  logic            row_held;
  logic            rep_fire;
  logic [3:0]      code;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign row_low[gi] = ~rows[gi];
    end
  endgenerate

  always_comb begin
    low_cnt = 3'd0;
    row_sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (row_low[i]) begin
        low_cnt = low_cnt + 3'd1;
        row_sel = 2'(i);
      end
    end
  end

  always_comb begin
    case (cols_reg)
      4'b1101: col_sel = 2'd1;
      4'b1011: col_sel = 2'd2;
      4'b0111: col_sel = 2'd3;
      default: col_sel = 2'd0;
    endcase
  end

  assign row_held = row_low[row_idx_reg];
  assign code     = key_map(row_idx_reg, col_idx_reg);

`ifdef KEYSCAN_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_reg;

  assign rep_fire = (state_reg == HELD) && row_held && (rep_reg == REP_LAST);

  // Outside HELD the counter sits at zero, so every entry into HELD starts a fresh period.
  always_ff @(posedge int_osc) begin
    if (reset || state_reg != HELD || !row_held || rep_fire) rep_reg <= '0;
    else                                                     rep_reg <= rep_reg + 1'b1;
  end
`else
  assign rep_fire = (REPEAT_CYCLES < 0);
`endif

  always_comb begin
    state_next     = state_reg;
    cols_next      = cols_reg;
    dwell_next     = dwell_reg;
    deb_next       = deb_reg;
    quiet_next     = quiet_reg;
    row_idx_next   = row_idx_reg;
    col_idx_next   = col_idx_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    keypress_next  = keypress_reg;
    alarm_next     = 1'b0;
    case (state_reg)
      SCAN: begin
        if (dwell_reg == DWELL_LAST) begin
          dwell_next = '0;
          cols_next  = {cols_reg[2:0], cols_reg[3]};
        end else begin
          dwell_next = dwell_reg + 1'b1;
        end
        if (quiet_reg != QUIET_FULL) quiet_next = quiet_reg + 1'b1;
        if (dwell_reg >= SETTLE_VAL) begin
          // Until a full quiet rotation follows reset, a key held across reset stays unreported.
          if (low_cnt != 3'd0 && quiet_reg != QUIET_FULL) quiet_next = '0;
          if (low_cnt > 3'd1) begin
            alarm_next = 1'b1;
          end else if (low_cnt == 3'd1 && quiet_reg == QUIET_FULL) begin
            state_next   = DEBOUNCE;
            row_idx_next = row_sel;
            col_idx_next = col_sel;
            cols_next    = cols_reg;
            dwell_next   = '0;
            deb_next     = '0;
          end
        end
      end
      DEBOUNCE: begin
        if (!row_held) begin
          state_next = SCAN;
          dwell_next = '0;
        end else if (deb_reg == DEB_FULL) begin
          state_next     = HELD;
          key_valid_next = 1'b1;
          key_code_next  = code;
          keypress_next  = {keypress_reg[3:0], code};
        end else begin
          deb_next = deb_reg + 1'b1;
        end
      end
      HELD: begin
        if (!row_held) begin
          state_next = RELEASE;
          deb_next   = '0;
        end else if (rep_fire) begin
          key_valid_next = 1'b1;
          key_code_next  = code;
          keypress_next  = {keypress_reg[3:0], code};
        end
      end
      default: begin
        if (row_held) begin
          state_next = HELD;
        end else if (deb_reg == DEB_LAST) begin
          state_next = SCAN;
          dwell_next = '0;
        end else begin
          deb_next = deb_reg + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge int_osc) begin
    if (reset) begin
      state_reg     <= SCAN;
      cols_reg      <= 4'b1110;
      dwell_reg     <= '0;
      deb_reg       <= '0;
      quiet_reg     <= '0;
      row_idx_reg   <= 2'd0;
      col_idx_reg   <= 2'd0;
      key_code_reg  <= 4'h0;
      key_valid_reg <= 1'b0;
      keypress_reg  <= 8'h00;
      alarm_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cols_reg      <= cols_next;
      dwell_reg     <= dwell_next;
      deb_reg       <= deb_next;
      quiet_reg     <= quiet_next;
      row_idx_reg   <= row_idx_next;
      col_idx_reg   <= col_idx_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      keypress_reg  <= keypress_next;
      alarm_reg     <= alarm_next;
    end
  end

  assign cols      = cols_reg;
  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign keypress  = keypress_reg;
  assign alarm     = alarm_reg;

endmodule

// File: tb/tb_lab3_dg_keyscan.sv
// Directed bench for lab3_dg_keyscan: keypad model shorts pressed rows to driven columns.
module tb_lab3_dg_keyscan;

  localparam int SCAN_DIV = 8;

  logic       int_osc = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic [7:0] keypress;
  logic       alarm;
  logic [15:0] keys;   // bit r*4+c = key at row r, column c is pressed

  int checks = 0;
  int errors = 0;
  int kv_count = 0;
  int alarm_count = 0;
  int kv_base;
  int n;
  logic [3:0] c0;

  lab3_dg_keyscan #(
    .SCAN_DIV(SCAN_DIV), .SETTLE_CYCLES(2), .DEBOUNCE_CYCLES(16), .REPEAT_CYCLES(40)
  ) dut (
    .int_osc(int_osc), .reset(reset), .rows(rows), .cols(cols),
    .key_code(key_code), .key_valid(key_valid), .keypress(keypress), .alarm(alarm)
  );

  always #5 int_osc = ~int_osc;

  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  always @(negedge int_osc) begin
    if (reset === 1'b0) begin
      if (key_valid === 1'b1) begin
        kv_count++;
        $display("key_valid strobe: key_code=%h keypress=%h", key_code, keypress);
      end
      if (alarm === 1'b1) alarm_count++;
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge int_osc);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_rotate(input string tag);
    c0 = cols;
    cyc(SCAN_DIV);
    check(tag, {28'd0, cols}, {28'd0, c0[2:0], c0[3]});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cols"},      {28'd0, cols},     32'hE);
    check({tag, "_key_code"},  {28'd0, key_code}, 32'h0);
    check({tag, "_key_valid"}, {31'd0, key_valid}, 32'h0);
    check({tag, "_keypress"},  {24'd0, keypress}, 32'h00);
    check({tag, "_alarm"},     {31'd0, alarm},    32'h0);
  endtask

  initial begin
    keys  = 16'h0000;
    reset = 1'b1;
    cyc(2);
    check_reset_values("reset");
    reset = 1'b0;
    cyc(40);
    check_rotate("rotate_idle");

    // Key 5 (r1,c1), held 100 clk
    keys[5] = 1'b1;
    cyc(100);
    check("k5_count", kv_count, 1);
    check("k5_code", {28'd0, key_code}, 32'h5);
    check("k5_keypress", {24'd0, keypress}, 32'h05);
    check("k5_cols_frozen", {28'd0, cols}, 32'hD);
    keys = 16'h0000;
    cyc(40);
    check("k5_release_count", kv_count, 1);
    check_rotate("rotate_after_k5");

    // Key 9 (r2,c2)
    keys[10] = 1'b1;
    cyc(100);
    check("k9_count", kv_count, 2);
    check("k9_code", {28'd0, key_code}, 32'h9);
    check("k9_keypress", {24'd0, keypress}, 32'h59);
    keys = 16'h0000;
    cyc(40);

    // Key 7 (r2,c0) pressed 6 clk from the start of column 0: aborted debounce
    n = 0;
    while (cols === 4'b1110 && n < 40) begin cyc(1); n++; end
    n = 0;
    while (cols !== 4'b1110 && n < 40) begin cyc(1); n++; end
    check("sync_col0", {31'd0, n < 40}, 32'h1);
    keys[8] = 1'b1;
    cyc(6);
    keys = 16'h0000;
    cyc(10);
    check("k7_short_count", kv_count, 2);
    check_rotate("rotate_after_k7");
    cyc(30);

    // Key 5 with a 3-clk bounce at release
    keys[5] = 1'b1;
    cyc(100);
    keys[5] = 1'b0; cyc(1);
    keys[5] = 1'b1; cyc(1);
    keys[5] = 1'b0; cyc(1);
    cyc(40);
    check("bounce_count", kv_count, 3);
    check("bounce_code", {28'd0, key_code}, 32'h5);
    check("bounce_keypress", {24'd0, keypress}, 32'h95);

    // Keys 2 and 8 together on column 1
    alarm_count = 0;
    keys[1] = 1'b1;
    keys[9] = 1'b1;
    cyc(40);
    check("multi_alarm_seen", {31'd0, alarm_count >= 6}, 32'h1);
    check("multi_count", kv_count, 3);
    keys = 16'h0000;
    cyc(10);
    check("multi_alarm_clear", {31'd0, alarm}, 32'h0);
    cyc(30);

    // Key 3 (r0,c2) accepted, then reset while held
    keys[2] = 1'b1;
    cyc(80);
    check("k3_count", kv_count, 4);
    check("k3_keypress", {24'd0, keypress}, 32'h53);
    reset = 1'b1;
    cyc(1);
    check_reset_values("midreset");
    reset = 1'b0;
    kv_base = kv_count;
    cyc(100);
    check("held_over_reset_count", kv_count, kv_base);
    keys = 16'h0000;
    cyc(60);
    keys[2] = 1'b1;
    cyc(80);
    check("repress_count", kv_count, kv_base + 1);
    check("repress_keypress", {24'd0, keypress}, 32'h03);
    keys = 16'h0000;
    cyc(40);

`ifdef KEYSCAN_REPEAT_EN
    // Key A (r0,c3): accept, then 3 repeats at 40-clk spacing over 120 clk
    kv_base = kv_count;
    keys[3] = 1'b1;
    n = 0;
    while (key_valid !== 1'b1 && n < 100) begin cyc(1); n++; end
    check("kA_accept_seen", {31'd0, n < 100}, 32'h1);
    kv_base = kv_count;
    cyc(120);
    check("kA_repeat_count", kv_count, kv_base + 3);
    check("kA_keypress", {24'd0, keypress}, 32'hAA);
    keys = 16'h0000;
    cyc(40);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
